// File: rtl/enc_pol_pkg.sv
// Shared types and line-pattern constants for the polarity line-bus receiver.
// A2=1 uses one-hot images with bits 0/1 swapped; A2=0 uses their bitwise inverses.
package enc_pol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam logic [3:0] IMG_00 = 4'b0010;
  localparam logic [3:0] IMG_01 = 4'b0001;
  localparam logic [3:0] IMG_10 = 4'b0100;
  localparam logic [3:0] IMG_11 = 4'b1000;

  typedef struct packed {
    logic       legal;
    logic       a2;
    logic [1:0] a;
  } dec_t;

endpackage

// File: rtl/enc4to2_pol_lut.sv
// Combinational decode of one line vector into {legal, A2, A[1:0]}.
// A2=0 patterns are recognised by inverting them back onto the one-hot images.
module enc4to2_pol_lut
  import enc_pol_pkg::*;
(
  input  logic [3:0] d_i,
  output dec_t       dec_o
);

  logic [3:0] onehot;

  always_comb begin
    dec_o  = '0;
    onehot = '0;
    if ($onehot(d_i)) begin
      dec_o.a2 = 1'b1;
      onehot   = d_i;
    end else if ($onehot(~d_i)) begin
      onehot   = ~d_i;
    end
    dec_o.legal = (onehot != 4'b0000);
    case (onehot)
      IMG_00:  dec_o.a = 2'd0;
      IMG_01:  dec_o.a = 2'd1;
      IMG_10:  dec_o.a = 2'd2;
      IMG_11:  dec_o.a = 2'd3;
      default: dec_o.a = 2'd0;
    endcase
  end

endmodule

// File: rtl/enc4to2_pol_rx.sv
// Receive-side encoder: qualifies D for STABLE_CYCLES samples, emits {A2,A1,A0}
// through a one-entry valid/ready register, and keeps illegal/overrun statistics.
module enc4to2_pol_rx
  import enc_pol_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [3:0]           d_in,
  input  logic                 out_ready,
  input  logic                 clr_stat,
  output logic                 out_valid,
  output logic [2:0]           out_code,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           d_q, d_d;
  logic                 same;
  logic                 event_s;
  dec_t                 dec;

  logic                 out_valid_q, out_valid_d;
  logic [2:0]           out_code_q, out_code_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 overrun_q, overrun_d;

  enc4to2_pol_lut u_lut (
    .d_i   (d_in),
    .dec_o (dec)
  );

  // A sample only extends the run if the previous edge also sampled the same vector.
  assign same = (state_q != IDLE) && (d_in == d_q);

  always_comb begin
    cnt_d = cnt_q;
    d_d   = d_q;
    if (!in_valid) begin
      cnt_d = '0;
    end else if (!same) begin
      d_d   = d_in;
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!in_valid) begin
      state_d = IDLE;
    end else if ((state_q == LOCK) && same) begin
      state_d = LOCK;
    end else begin
      state_d = (cnt_d == CNT_MAX) ? LOCK : QUAL;
    end
  end

  always_comb begin
    event_s = in_valid && (cnt_d == CNT_MAX) && !((state_q == LOCK) && same);
  end

  // New events win over a simultaneous transfer; a full, stalled register drops them.
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    overrun_d   = overrun_q;
    if (event_s) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_err_d   = !dec.legal;
        out_code_d  = dec.legal ? {dec.a2, dec.a} : 3'b000;
      end else begin
        overrun_d = 1'b1;
      end
      if (!dec.legal && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clr_stat) begin
      err_cnt_d = '0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_enc4to2_pol_rx.sv
// Self-checking bench for enc4to2_pol_rx: directed scenarios plus randomized traffic,
// all compared against a run-length based reference model.
module tb_enc4to2_pol_rx;

  localparam int SC = 3;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [3:0]    d_in;
  logic          out_ready;
  logic          clr_stat;
  logic          out_valid;
  logic [2:0]    out_code;
  logic          out_err;
  logic [EW-1:0] err_cnt;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  bit         mValid;
  logic [2:0] mCode;
  bit         mErr;
  int         mErrCnt;
  bit         mOverrun;
  bit         lastValid;
  logic [3:0] lastD;
  int         run;

  enc4to2_pol_rx #(
    .STABLE_CYCLES (SC),
    .ERR_CNT_W     (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d_in      (d_in),
    .out_ready (out_ready),
    .clr_stat  (clr_stat),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Returns {legal, A2, A1, A0} straight from the pattern table.
  function automatic logic [3:0] refDecode(input logic [3:0] d);
    case (d)
      4'b0010: return 4'b1100;
      4'b0001: return 4'b1101;
      4'b0100: return 4'b1110;
      4'b1000: return 4'b1111;
      4'b1101: return 4'b1000;
      4'b1110: return 4'b1001;
      4'b1011: return 4'b1010;
      4'b0111: return 4'b1011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    mValid = 0; mCode = '0; mErr = 0; mErrCnt = 0; mOverrun = 0;
    lastValid = 0; lastD = '0; run = 0;
  endtask

  // An event fires when the run of identical consecutive valid samples reaches SC exactly.
  task automatic modelEdge(input bit v, input logic [3:0] d, input bit rdy, input bit clr);
    bit         ev;
    logic [3:0] dec;
    if (v) begin
      if (lastValid && d == lastD) run++;
      else run = 1;
      lastD = d;
    end else begin
      run = 0;
    end
    lastValid = v;
    ev  = v && (run == SC);
    dec = refDecode(d);
    if (ev) begin
      if (!mValid || rdy) begin
        mValid = 1;
        mErr   = !dec[3];
        mCode  = dec[3] ? dec[2:0] : 3'b000;
      end else begin
        mOverrun = 1;
      end
      if (!dec[3] && mErrCnt < (1 << EW) - 1) mErrCnt++;
    end else if (mValid && rdy) begin
      mValid = 0;
    end
    if (clr) begin
      mErrCnt  = 0;
      mOverrun = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"},   32'(out_valid), 32'(mValid));
    checkOutput({tag, ".code"},    32'(out_code),  32'(mCode));
    checkOutput({tag, ".err"},     32'(out_err),   32'(mErr));
    checkOutput({tag, ".errcnt"},  32'(err_cnt),   32'(mErrCnt));
    checkOutput({tag, ".overrun"}, 32'(overrun),   32'(mOverrun));
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] d, input bit rdy,
                               input bit clr, input string tag);
    @(negedge clk);
    in_valid = v; d_in = d; out_ready = rdy; clr_stat = clr;
    @(posedge clk);
    modelEdge(v, d, rdy, clr);
    #1;
    checkAll(tag);
  endtask

  logic [3:0] legalPats [8] = '{4'b0010, 4'b0001, 4'b0100, 4'b1000,
                                4'b1101, 4'b1110, 4'b1011, 4'b0111};

  initial begin
    int         pulses;
    int         hold;
    logic [3:0] cur;

    in_valid = 0; d_in = '0; out_ready = 1; clr_stat = 0;
    rst_n = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1;

    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 4'b0010, 1, 0, "t1");
      if (out_valid) pulses++;
      if (i == 2) checkOutput("t1.code", 32'(out_code), 32'(3'b100));
    end
    checkOutput("t1.pulses", 32'(pulses), 32'd1);
    applyStimulus(0, 4'b0000, 1, 0, "t1.gap");

    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b1110, 1, 0, "t2a");
    checkOutput("t2.code1", 32'(out_code), 32'(3'b001));
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0111, 1, 0, "t2b");
    checkOutput("t2.code2", 32'(out_code), 32'(3'b011));
    applyStimulus(0, 4'b0000, 1, 0, "t2.gap");

    applyStimulus(1, 4'b0100, 1, 0, "t3");
    applyStimulus(1, 4'b0100, 1, 0, "t3");
    checkOutput("t3.nobounce", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b1000, 1, 0, "t3");
    checkOutput("t3.code", 32'(out_code), 32'(3'b111));
    applyStimulus(0, 4'b0000, 1, 0, "t3.gap");

    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0011, 1, 0, "t4a");
    checkOutput("t4.err", 32'(out_err), 32'd1);
    checkOutput("t4.cnt1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b1111, 1, 0, "t4b");
    checkOutput("t4.cnt2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0000, 1, 0, "t4c");
    checkOutput("t4.cnt3", 32'(err_cnt), 32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0110, 1, 0, "t4d");
    checkOutput("t4.sat", 32'(err_cnt), 32'd3);
    applyStimulus(0, 4'b0000, 1, 1, "t4.clr");
    checkOutput("t4.cleared", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0010, 0, 0, "t5a");
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0001, 0, 0, "t5b");
    checkOutput("t5.held", 32'(out_code), 32'(3'b100));
    checkOutput("t5.overrun", 32'(overrun), 32'd1);
    applyStimulus(0, 4'b0000, 1, 0, "t5.xfer");
    checkOutput("t5.drained", 32'(out_valid), 32'd0);
    applyStimulus(0, 4'b0000, 1, 1, "t5.clr");
    checkOutput("t5.ovclr", 32'(overrun), 32'd0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0100, 0, 0, "t6a");
    applyStimulus(1, 4'b1000, 0, 0, "t6b");
    applyStimulus(1, 4'b1000, 0, 0, "t6b");
    #2;
    rst_n = 0;
    in_valid = 0;
    #1;
    modelReset();
    checkAll("t6.rst");
    @(negedge clk);
    rst_n = 1;
    applyStimulus(1, 4'b1000, 1, 0, "t6c");
    applyStimulus(1, 4'b1000, 1, 0, "t6c");
    checkOutput("t6.noevent", 32'(out_valid), 32'd0);
    applyStimulus(1, 4'b1000, 1, 0, "t6c");
    checkOutput("t6.event", 32'(out_code), 32'(3'b111));

    hold = 0;
    cur  = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 6);
        if ($urandom_range(0, 3) != 0) cur = legalPats[$urandom_range(0, 7)];
        else cur = 4'($urandom);
      end
      hold--;
      applyStimulus($urandom_range(0, 9) != 0, cur, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 24) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
